// File: rtl/udma_smi_seq_if.sv
// Bundle between the SMI command sequencer and its neighbours: the uDMA
// register/config side (command/response queues) and the SMI controller
// (start/busy/nd). The sequencer takes the slave view; the environment
// (config side plus controller) takes the master view.
//
// Handshakes: a command moves on a rising clk_i edge where cmd_valid_i and
// cmd_ready_o are both 1; a response moves on a rising edge where
// rsp_valid_o and rsp_ready_i are both 1. Valid never waits for ready, and
// data is stable while valid is held without a transfer.
interface udma_smi_seq_if;
  logic        clr_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [26:0] cmd_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_data_o;
  logic        busy_o;
  logic        err_o;
  logic        ctrl_start_o;
  logic        ctrl_rw_o;
  logic [4:0]  ctrl_phy_addr_o;
  logic [4:0]  ctrl_reg_addr_o;
  logic [15:0] ctrl_wr_data_o;
  logic        ctrl_busy_i;
  logic        ctrl_nd_i;
  logic [15:0] ctrl_rd_data_i;
  // FSM state for debug and checkers: 0=IDLE, 1=ACCEPT, 2=DONE.
  logic [1:0]  state_dbg;

  modport slave (
    input  clr_i, cmd_valid_i, cmd_data_i, rsp_ready_i,
           ctrl_busy_i, ctrl_nd_i, ctrl_rd_data_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, busy_o, err_o,
           ctrl_start_o, ctrl_rw_o, ctrl_phy_addr_o, ctrl_reg_addr_o,
           ctrl_wr_data_o, state_dbg
  );

  modport master (
    output clr_i, cmd_valid_i, cmd_data_i, rsp_ready_i,
           ctrl_busy_i, ctrl_nd_i, ctrl_rd_data_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, busy_o, err_o,
           ctrl_start_o, ctrl_rw_o, ctrl_phy_addr_o, ctrl_reg_addr_o,
           ctrl_wr_data_o, state_dbg
  );
endinterface

// File: rtl/udma_smi_seq.sv
// SMI (MDIO) command sequencer. Queues management commands, issues them one
// at a time to the SMI controller, holds the operands stable for the whole
// frame, returns read data through a response FIFO and aborts any phase
// that exceeds TIMEOUT_CYCLES.
module udma_smi_seq #(
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input logic           clk_i,
  input logic           rstn_i,
  udma_smi_seq_if.slave bus
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CAW:0]  CMD_FULL = (CAW+1)'(CMD_DEPTH);
  localparam logic [RAW:0]  RSP_FULL = (RAW+1)'(RSP_DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Command FIFO
  logic [26:0]    cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wptr, cmd_rptr;
  logic [CAW:0]   cmd_cnt;
  logic           cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [26:0]    cmd_head;

  // Response FIFO
  logic [15:0]    rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wptr, rsp_rptr;
  logic [RAW:0]   rsp_cnt;
  logic           rsp_full, rsp_empty, rsp_push, rsp_pop;

  // Transaction control
  logic          issue, done_ok, timeout_hit, set_err, rsp_req;
  logic          start_q, err_q;
  logic          rw_q;
  logic [4:0]    phy_q, reg_q;
  logic [15:0]   wdata_q;
  logic [TW-1:0] timer;

  assign cmd_full  = (cmd_cnt == CMD_FULL);
  assign cmd_empty = (cmd_cnt == '0);
  assign cmd_head  = cmd_mem[cmd_rptr];
  // A flush in the same cycle drops the incoming command.
  assign cmd_push  = bus.cmd_valid_i & ~cmd_full & ~bus.clr_i;
  assign cmd_pop   = issue;

  assign rsp_full  = (rsp_cnt == RSP_FULL);
  assign rsp_empty = (rsp_cnt == '0);
  assign rsp_push  = rsp_req & ~rsp_full & ~bus.clr_i;
  assign rsp_pop   = bus.rsp_ready_i & ~rsp_empty & ~bus.clr_i;

  // A read completes only on nd; a write completes on the first idle busy.
  assign done_ok     = (state == S_DONE) & (rw_q ? ~bus.ctrl_busy_i : bus.ctrl_nd_i);
  assign timeout_hit = (state != S_IDLE) & (timer == T_LAST);

  // Command FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cmd_wptr <= '0;
      cmd_rptr <= '0;
      cmd_cnt  <= '0;
    end else if (bus.clr_i) begin
      cmd_wptr <= '0;
      cmd_rptr <= '0;
      cmd_cnt  <= '0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + CAW'(1);
      if (cmd_pop)  cmd_rptr <= cmd_rptr + CAW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt <= cmd_cnt + (CAW+1)'(1);
        2'b01:   cmd_cnt <= cmd_cnt - (CAW+1)'(1);
        default: cmd_cnt <= cmd_cnt;
      endcase
    end
  end

  // Command FIFO storage
  always_ff @(posedge clk_i) begin
    if (cmd_push) cmd_mem[cmd_wptr] <= bus.cmd_data_i;
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_wptr <= '0;
      rsp_rptr <= '0;
      rsp_cnt  <= '0;
    end else if (bus.clr_i) begin
      rsp_wptr <= '0;
      rsp_rptr <= '0;
      rsp_cnt  <= '0;
    end else begin
      if (rsp_push) rsp_wptr <= rsp_wptr + RAW'(1);
      if (rsp_pop)  rsp_rptr <= rsp_rptr + RAW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + (RAW+1)'(1);
        2'b01:   rsp_cnt <= rsp_cnt - (RAW+1)'(1);
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk_i) begin
    if (rsp_push) rsp_mem[rsp_wptr] <= bus.ctrl_rd_data_i;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue) state_nxt = S_ACCEPT;
      end
      S_ACCEPT: begin
        // Busy seen during the start-pulse cycle is stale; the controller
        // may not raise busy until its next slow-clock enable.
        if (timeout_hit)                           state_nxt = S_IDLE;
        else if (bus.ctrl_busy_i && !start_q)      state_nxt = S_DONE;
      end
      S_DONE: begin
        if (done_ok || timeout_hit) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: issue decision, response push, error set
  always_comb begin
    issue   = 1'b0;
    rsp_req = 1'b0;
    set_err = 1'b0;
    case (state)
      S_IDLE: begin
        // Never start a read without a slot to return its data into.
        issue = ~cmd_empty & (cmd_head[26] | ~rsp_full) & ~bus.clr_i;
      end
      S_ACCEPT: begin
        set_err = timeout_hit;
      end
      S_DONE: begin
        rsp_req = done_ok & ~rw_q;
        set_err = timeout_hit & ~done_ok;
      end
      default: ;
    endcase
  end

  // Phase watchdog: restarts on every state change, runs outside IDLE
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                 timer <= '0;
    else if (state_nxt != state) timer <= '0;
    else if (state != S_IDLE)    timer <= timer + TW'(1);
  end

  // Operand hold: loaded only when a command is issued
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rw_q    <= 1'b0;
      phy_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
    end else if (issue) begin
      rw_q    <= cmd_head[26];
      phy_q   <= cmd_head[25:21];
      reg_q   <= cmd_head[20:16];
      wdata_q <= cmd_head[15:0];
    end
  end

  // One-cycle start pulse, aligned with the freshly loaded operands
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) start_q <= 1'b0;
    else         start_q <= issue;
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)          err_q <= 1'b0;
    else if (set_err)     err_q <= 1'b1;
    else if (bus.clr_i)   err_q <= 1'b0;
  end

  assign bus.cmd_ready_o     = ~cmd_full;
  assign bus.rsp_valid_o     = ~rsp_empty;
  assign bus.rsp_data_o      = rsp_mem[rsp_rptr];
  assign bus.busy_o          = (state != S_IDLE) | ~cmd_empty;
  assign bus.err_o           = err_q;
  assign bus.ctrl_start_o    = start_q;
  assign bus.ctrl_rw_o       = rw_q;
  assign bus.ctrl_phy_addr_o = phy_q;
  assign bus.ctrl_reg_addr_o = reg_q;
  assign bus.ctrl_wr_data_o  = wdata_q;
  assign bus.state_dbg       = state;

endmodule

// File: doc/udma_smi_seq.md
Name: udma_smi_seq

Overview:
Command sequencer that sits directly upstream of the uDMA SMI (MDIO) controller.
- Buffers queued management-bus commands from the uDMA register/config side in a command FIFO.
- Issues them one at a time to the controller's start/busy/nd interface and holds the operands stable for the whole frame.
- Returns read results through a response FIFO with a valid/ready handshake.
- Supervises each transaction with a timeout watchdog.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 65536, max clk_i cycles per phase (accept or done) before abort

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
clr_i  in  1  sync flush of both FIFOs and err_o
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command FIFO not full
cmd_data_i  in  27  {rw[26] (1=write), phy[25:21], reg[20:16], wdata[15:0]}
rsp_valid_o  out  1  response FIFO not empty
rsp_ready_i  in  1  response consumed
rsp_data_o  out  16  read data at FIFO head
busy_o  out  1  FSM not IDLE, or command FIFO non-empty
err_o  out  1  sticky timeout flag
ctrl_start_o  out  1  one-cycle start pulse to the controller
ctrl_rw_o  out  1  operand hold
ctrl_phy_addr_o  out  5  operand hold
ctrl_reg_addr_o  out  5  operand hold
ctrl_wr_data_o  out  16  operand hold
ctrl_busy_i  in  1  controller busy
ctrl_nd_i  in  1  controller read-data-valid pulse
ctrl_rd_data_i  in  16  controller read data

Behaviour:
Reset state
- All FIFO pointers/counts are 0; FSM is IDLE; timeout counter is 0.
- Outputs at reset: cmd_ready_o=1, rsp_valid_o=0, busy_o=0, err_o=0, ctrl_start_o=0.
- Operand-hold outputs (ctrl_rw_o, ctrl_phy_addr_o, ctrl_reg_addr_o, ctrl_wr_data_o) are 0.

FIFOs
- Both are synchronous, with registered pointers and first-word fall-through.
- Command push when cmd_valid_i & cmd_ready_o. Response pop when rsp_valid_o & rsp_ready_i.
- Simultaneous push and pop on the same FIFO: count is unchanged.
- Pointers wrap modulo depth. Push when full / pop when empty is ignored.

FSM
- IDLE:
  - Conditions to proceed: command FIFO non-empty, AND (head rw=1 OR response FIFO not full).
  - Action: pop the head into the operand-hold registers, assert ctrl_start_o for exactly 1 cycle, go to ACCEPT.
  - A read is never issued without a free response slot.
- ACCEPT:
  - Wait for ctrl_busy_i=1 in a cycle where ctrl_start_o=0, then go to DONE.
  - Required because the controller's busy can be low between the start pulse and its next slow-clock enable.
- DONE, write: complete on the first cycle with ctrl_busy_i=0, then go to IDLE.
- DONE, read:
  - Complete on ctrl_nd_i=1: push ctrl_rd_data_i into the response FIFO, go to IDLE.
  - ctrl_busy_i falling alone does not complete a read.
- Operand-hold registers change only on an IDLE pop. They stay stable from start through completion, because the controller samples them later, at its own clock enable.

Latency and throughput
- Command-FIFO head to ctrl_start_o: 1 cycle.
- At most one transaction in flight at any time.
- Back-to-back commands: the next start is issued no earlier than the cycle after completion.

Timeout
- The counter clears on every state entry and increments each cycle in ACCEPT and DONE.
- On reaching TIMEOUT_CYCLES-1: set err_o, return to IDLE, push no response.
- The queue keeps draining after a timeout; err_o does not stall issue.

clr_i
- Empties both FIFOs and clears err_o on the same clock edge.
- Does not abort an in-flight transaction; it completes on the wire.
- A read completing after a clr is still pushed into the (now empty) response FIFO. The software contract is to clr only when busy_o=0.
- clr_i together with cmd push: the flush wins and the command is dropped.

Reset mid-transaction
- The asynchronous reset returns everything to the reset state immediately.
- The controller shares rstn_i, so no frame resumes after reset.

Test Plan:
- Single write {1,5'h01,5'h00,16'h1140}:
  - One ctrl_start_o pulse; operands held at those values until ctrl_busy_i falls.
  - No response pushed; busy_o=0 one cycle after completion.
- Single read {0,5'h03,5'h02}, controller model returns 16'h0141 with nd:
  - rsp_valid_o=1 with rsp_data_o=16'h0141 the cycle after nd.
  - Pop via rsp_ready_i, then rsp_valid_o=0.
- Busy-gap check: model keeps ctrl_busy_i=0 for 40 cycles after start, then high for 500 cycles, then low.
  - FSM must stay in ACCEPT through the gap.
  - Exactly one start pulse; completion only on the final fall.
- Queue 4 reads with RSP_DEPTH=4 and rsp_ready_i=0, then a 5th read:
  - 4 starts issued; the 5th is not started until one response is popped.
  - cmd_ready_o follows FIFO occupancy.
- Timeout with TIMEOUT_CYCLES=100: model never asserts busy.
  - err_o=1 at cycle 100 after start; no response; next queued write still issues.
  - clr_i clears err_o.
- Assert rstn_i low during DONE of a read:
  - All outputs at reset values; the queued command is discarded; no response after release.
